// File: rtl/wb_sram_slave_pkg.sv
// Shared Wishbone burst codes and SRAM target state type.
// No logic; imported by the SRAM target and its burst address helper.
// Backpressure: not applicable.
package wb_sram_slave_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } wb_sram_state_e;

    // Number of low address bits that wrap for a given burst type; 0 means linear.
    function automatic int unsigned wrap_bits(input logic [1:0] bte);
        case (bte)
            BTE_WRAP4:  return 2;
            BTE_WRAP8:  return 3;
            BTE_WRAP16: return 4;
            default:    return 0;
        endcase
    endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 bus bundle with master and slave views.
// Pure wiring, zero latency.
// Backpressure: carried by ack/err from the slave.
interface wb_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic [DW/8-1:0] sel;
    logic            cyc;
    logic            stb;
    logic            we;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic            ack;
    logic            err;

    modport master (
        output adr, dat_w, sel, cyc, stb, we, cti, bte,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, cyc, stb, we, cti, bte,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_burst_addr_next.sv
// Next word index of a Wishbone incrementing burst (linear or wrap-4/8/16).
// Purely combinational, zero latency.
// Backpressure: none; caller decides when to advance.
module wb_burst_addr_next
    import wb_sram_slave_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 10
) (
    input  logic [MEM_ADDR_BITS-1:0] addr,
    input  logic [1:0]               bte,
    output logic [MEM_ADDR_BITS-1:0] next_addr
);

    logic [MEM_ADDR_BITS-1:0] incr;
    logic [MEM_ADDR_BITS-1:0] wrap_mask;

    // Bits under wrap_mask take the incremented value; the rest hold the wrap block.
    always_comb begin
        incr      = addr + MEM_ADDR_BITS'(1);
        wrap_mask = '1;
        if (bte != BTE_LINEAR) begin
            wrap_mask = ~({MEM_ADDR_BITS{1'b1}} << wrap_bits(bte));
        end
        next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
    end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B4 SRAM target with classic, constant and incrementing bursts; WB_SRAM_SLAVE_DECERR_EN adds range errors.
// Latency: first beat acked one cycle after STB, then one beat per clock; classic accesses take 2 cycles.
// Backpressure: STB low holds the burst address; CYC low abandons the cycle.
module wb_sram_slave
    import wb_sram_slave_pkg::*;
#(
    parameter int                       WB_ADDR_WIDTH = 32,
    parameter int                       WB_DATA_WIDTH = 32,
    parameter int                       MEM_ADDR_BITS = 10,
    parameter logic [WB_ADDR_WIDTH-1:0] ADDR_BASE     = '0
) (
    input  logic clk,
    input  logic rst,
    wb_if.slave  s
);

    localparam int SEL_WIDTH = WB_DATA_WIDTH / 8;
    localparam int LSB       = $clog2(SEL_WIDTH);
    localparam int WORD_BITS = WB_ADDR_WIDTH - LSB;
    localparam int MEM_DEPTH = 1 << MEM_ADDR_BITS;

    logic [WB_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    wb_sram_state_e           state_q;
    logic [WORD_BITS-1:0]     addr_q;
    logic                     in_range_q;

    logic [WB_ADDR_WIDTH-1:0] byte_off;
    logic [WORD_BITS-1:0]     word_off;
    logic [MEM_ADDR_BITS-1:0] mem_idx;
    logic [MEM_ADDR_BITS-1:0] idx_nxt;
    logic [WORD_BITS-1:0]     addr_nxt;
    logic                     start_in_range;
    logic                     nxt_in_range;
    logic                     beat;
    logic                     ack;
    logic                     err;

    assign byte_off = s.adr - ADDR_BASE;
    assign word_off = WORD_BITS'(byte_off >> LSB);
    assign mem_idx  = addr_q[MEM_ADDR_BITS-1:0];

    wb_burst_addr_next #(
        .MEM_ADDR_BITS (MEM_ADDR_BITS)
    ) u_addr_next (
        .addr      (mem_idx),
        .bte       (s.bte),
        .next_addr (idx_nxt)
    );

    // Upper word bits ride along so an out-of-range burst stays out of range.
    assign addr_nxt = {addr_q[WORD_BITS-1:MEM_ADDR_BITS], idx_nxt};

    assign beat = (state_q == ST_ACTIVE) && s.cyc && s.stb;

`ifdef WB_SRAM_SLAVE_DECERR_EN
    assign start_in_range = (word_off[WORD_BITS-1:MEM_ADDR_BITS] == '0);
    assign nxt_in_range   = (addr_nxt[WORD_BITS-1:MEM_ADDR_BITS] == '0);
    assign ack            = beat && in_range_q;
    assign err            = beat && !in_range_q;
`else
    logic unused_range;
    assign start_in_range = 1'b1;
    assign nxt_in_range   = 1'b1;
    assign ack            = beat;
    assign err            = 1'b0;
    assign unused_range   = in_range_q;
`endif

    assign s.ack   = ack;
    assign s.err   = err;
    assign s.dat_r = ack ? mem[mem_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            in_range_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s.cyc && s.stb) begin
                        addr_q     <= word_off;
                        in_range_q <= start_in_range;
                        state_q    <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (!s.cyc) begin
                        state_q <= ST_IDLE;
                    end else if (s.stb) begin
                        // Errored beats follow the same CTI sequencing as acked ones.
                        case (s.cti)
                            CTI_CONST: begin
                                state_q <= ST_ACTIVE;
                            end
                            CTI_INCR: begin
                                addr_q     <= addr_nxt;
                                in_range_q <= nxt_in_range;
                            end
                            default: begin
                                state_q <= ST_IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // A beat caught by reset must not land in memory.
    always_ff @(posedge clk) begin
        if (!rst && ack && s.we) begin
            for (int i = 0; i < SEL_WIDTH; i++) begin
                if (s.sel[i]) begin
                    mem[mem_idx][8*i +: 8] <= s.dat_w[8*i +: 8];
                end
            end
        end
    end

    a_ack_err_excl: assert property (@(posedge clk) !(s.ack && s.err));
    a_idle_silent:  assert property (@(posedge clk) (state_q == ST_IDLE) |-> !(s.ack || s.err));

endmodule

// File: tb/tb_wb_sram_slave.sv
// Randomised Wishbone transactions against a word-array reference model plus directed corner cases.
module tb_wb_sram_slave;
    import wb_sram_slave_pkg::*;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          WORDS = 1024;
`ifdef WB_SRAM_SLAVE_DECERR_EN
    localparam bit DECERR = 1'b1;
`else
    localparam bit DECERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_if #(.AW(32), .DW(32)) bus ();

    wb_sram_slave #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .MEM_ADDR_BITS (10),
        .ADDR_BASE     (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] ref_mem [WORDS];
    bit          known   [WORDS];
    logic [31:0] rd_q [$];
    bit          force_sel_en = 1'b0;
    logic [3:0]  force_sel    = 4'hF;
    bit          force_dat_en = 1'b0;
    logic [31:0] force_dat    = 32'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        bus.cyc   = 1'b0;
        bus.stb   = 1'b0;
        bus.we    = 1'b0;
        bus.sel   = 4'h0;
        bus.cti   = CTI_CLASSIC;
        bus.bte   = BTE_LINEAR;
        bus.adr   = 32'h0;
        bus.dat_w = 32'h0;
    endtask

    // Burst address sequence from the rules: linear wraps at memory size, wrap-N within an N-aligned block.
    function automatic int unsigned next_w(input int unsigned w, input logic [1:0] bte);
        int unsigned lo, hi, n;
        lo = w % WORDS;
        hi = w - lo;
        n  = (bte == BTE_LINEAR) ? WORDS : (2 << bte);
        lo = (lo / n) * n + ((lo % n) + 1) % n;
        return hi + lo;
    endfunction

    task automatic xfer(input logic [31:0] adr0, input logic [2:0] cti, input logic [1:0] bte,
                        input int nbeats, input int we_mode, input int wait_cyc);
        int unsigned w, idx;
        bit          inr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dw, exp_d;
        int          nw;
        w = (adr0 - BASE) >> 2;
        for (int b = 0; b < nbeats; b++) begin
            we  = (we_mode == 2) ? 1'($urandom_range(0, 1)) : (we_mode == 1);
            sel = force_sel_en ? force_sel : 4'($urandom_range(0, 15));
            dw  = force_dat_en ? force_dat : $urandom;
            bus.cyc   = 1'b1;
            bus.stb   = 1'b1;
            bus.we    = we;
            bus.sel   = sel;
            bus.dat_w = dw;
            bus.bte   = bte;
            bus.adr   = BASE + (w << 2);
            bus.cti   = (cti == CTI_CLASSIC || b < nbeats - 1) ? cti : CTI_END;
            if (b == 0) begin
                sample();
                check("first_lat_ack", 64'(bus.ack), 64'(0));
                check("first_lat_err", 64'(bus.err), 64'(0));
                step();
            end
            inr   = !DECERR || (w < WORDS);
            idx   = w % WORDS;
            exp_d = inr ? ref_mem[idx] : 32'h0;
            sample();
            check("beat_ack", 64'(bus.ack), 64'(inr));
            check("beat_err", 64'(bus.err), 64'(!inr));
            if (known[idx] || !inr) check("beat_dat", 64'(bus.dat_r), 64'(exp_d));
            if (!we && inr) rd_q.push_back(bus.dat_r);
            step();
            if (we && inr) begin
                for (int i = 0; i < 4; i++) begin
                    if (sel[i]) ref_mem[idx][8*i +: 8] = dw[8*i +: 8];
                end
                if (sel == 4'hF) known[idx] = 1'b1;
            end
            if (cti == CTI_INCR) w = next_w(w, bte);
            if (b < nbeats - 1) begin
                if (wait_cyc < 0) nw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
                else              nw = (b == 0) ? wait_cyc : 0;
                for (int k = 0; k < nw; k++) begin
                    bus.stb = 1'b0;
                    bus.we  = 1'b0;
                    sample();
                    check("wait_ack", 64'(bus.ack), 64'(0));
                    check("wait_err", 64'(bus.err), 64'(0));
                    step();
                end
            end
        end
        bus_idle();
        sample();
        check("idle_ack", 64'(bus.ack), 64'(0));
        check("idle_err", 64'(bus.err), 64'(0));
        check("idle_dat", 64'(bus.dat_r), 64'(0));
        step();
    endtask

    task automatic write_word(input int unsigned word, input logic [31:0] d, input logic [3:0] sel);
        force_sel_en = 1'b1;
        force_sel    = sel;
        force_dat_en = 1'b1;
        force_dat    = d;
        xfer(BASE + (word << 2), CTI_CLASSIC, BTE_LINEAR, 1, 1, 0);
        force_sel_en = 1'b0;
        force_dat_en = 1'b0;
    endtask

    initial begin
        int unsigned ws;
        int          nb, cs, exp_n;
        logic [2:0]  c;
        logic [31:0] old102, exp_last;

        bus_idle();
        rst = 1'b1;
        repeat (3) step();
        sample();
        check("rst_ack", 64'(bus.ack), 64'(0));
        check("rst_err", 64'(bus.err), 64'(0));
        check("rst_dat", 64'(bus.dat_r), 64'(0));
        step();
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        step();
        sample();
        check("rst_busy_ack", 64'(bus.ack), 64'(0));
        step();
        bus_idle();
        rst = 1'b0;
        step();

        // Whole-memory linear write burst so every model word is defined.
        force_sel_en = 1'b1;
        force_sel    = 4'hF;
        xfer(BASE, CTI_INCR, BTE_LINEAR, WORDS, 1, 0);
        force_sel_en = 1'b0;

        // Classic write then read.
        write_word(32'h4, 32'hDEADBEEF, 4'hF);
        rd_q.delete();
        xfer(BASE + 32'h10, CTI_CLASSIC, BTE_LINEAR, 1, 0, 0);
        check("classic_n", 64'(rd_q.size()), 64'(1));
        check("classic_rd", 64'(rd_q[0]), 64'(32'hDEADBEEF));

        // Byte lane merge.
        write_word(32'h4, 32'h11223344, 4'hF);
        write_word(32'h4, 32'hAABBCCDD, 4'b0010);
        rd_q.delete();
        xfer(BASE + 32'h10, CTI_CLASSIC, BTE_LINEAR, 1, 0, 0);
        check("lane_rd", 64'(rd_q[0]), 64'(32'h1122CC44));

        // Wrap-4 read starting mid-block.
        for (int i = 4; i < 8; i++) write_word(i, i, 4'hF);
        rd_q.delete();
        xfer(BASE + 32'h18, CTI_INCR, BTE_WRAP4, 4, 0, 0);
        check("wrap4_n", 64'(rd_q.size()), 64'(4));
        check("wrap4_b0", 64'(rd_q[0]), 64'(6));
        check("wrap4_b1", 64'(rd_q[1]), 64'(7));
        check("wrap4_b2", 64'(rd_q[2]), 64'(4));
        check("wrap4_b3", 64'(rd_q[3]), 64'(5));

        // Two master wait states after the first beat.
        for (int i = 0; i < 3; i++) write_word(i, 32'h100 + i, 4'hF);
        rd_q.delete();
        xfer(BASE, CTI_INCR, BTE_LINEAR, 3, 0, 2);
        check("wait_n", 64'(rd_q.size()), 64'(3));
        check("wait_b0", 64'(rd_q[0]), 64'(32'h100));
        check("wait_b1", 64'(rd_q[1]), 64'(32'h101));
        check("wait_b2", 64'(rd_q[2]), 64'(32'h102));

        // Just past the top of memory: error or alias onto word 0.
        write_word(0, 32'hCAFE0000, 4'hF);
        rd_q.delete();
        xfer(BASE + 32'h1000, CTI_CLASSIC, BTE_LINEAR, 1, 0, 0);
        write_word(32'h400, 32'h5555AAAA, 4'hF);
        xfer(BASE, CTI_CLASSIC, BTE_LINEAR, 1, 0, 0);
        exp_n    = DECERR ? 1 : 2;
        exp_last = DECERR ? 32'hCAFE0000 : 32'h5555AAAA;
        check("decode_n", 64'(rd_q.size()), 64'(exp_n));
        check("decode_word0", 64'(rd_q[rd_q.size() - 1]), 64'(exp_last));

        // Reset during beat 2 of an 8-beat write burst.
        old102    = ref_mem[102];
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = 1'b1;
        bus.sel   = 4'hF;
        bus.cti   = CTI_INCR;
        bus.bte   = BTE_LINEAR;
        bus.adr   = BASE + 32'd400;
        bus.dat_w = 32'h0BEA_0000;
        sample();
        check("rstb_lat", 64'(bus.ack), 64'(0));
        step();
        sample();
        check("rstb_b0", 64'(bus.ack), 64'(1));
        step();
        ref_mem[100] = 32'h0BEA_0000;
        bus.adr   = BASE + 32'd404;
        bus.dat_w = 32'h0BEA_0001;
        sample();
        check("rstb_b1", 64'(bus.ack), 64'(1));
        step();
        ref_mem[101] = 32'h0BEA_0001;
        bus.adr   = BASE + 32'd408;
        bus.dat_w = 32'h0BEA_0002;
        rst = 1'b1;
        step();
        rst = 1'b0;
        sample();
        check("rstb_after_ack", 64'(bus.ack), 64'(0));
        check("rstb_after_err", 64'(bus.err), 64'(0));
        step();
        bus_idle();
        step();
        rd_q.delete();
        for (int i = 100; i < 103; i++) xfer(BASE + 32'(i * 4), CTI_CLASSIC, BTE_LINEAR, 1, 0, 0);
        check("rstb_w0", 64'(rd_q[0]), 64'(32'h0BEA_0000));
        check("rstb_w1", 64'(rd_q[1]), 64'(32'h0BEA_0001));
        check("rstb_w2", 64'(rd_q[2]), 64'(old102));

        // Random mix of classic, constant and incrementing bursts with mixed direction.
        for (int t = 0; t < 200; t++) begin
            cs = $urandom_range(0, 2);
            c  = (cs == 0) ? CTI_CLASSIC : (cs == 1) ? CTI_CONST : CTI_INCR;
            nb = (c == CTI_CLASSIC) ? 1 : int'($urandom_range(2, 8));
            ws = ($urandom_range(0, 7) == 0) ? $urandom_range(WORDS, WORDS + 64) : $urandom_range(0, WORDS - 1);
            xfer(BASE + (ws << 2), c, 2'($urandom_range(0, 3)), nb, int'($urandom_range(0, 2)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
